// File: rtl/stoch_fixed_gain_mult_mat.sv
// Element-wise stochastic fixed-gain multiplier: each output stream carries min(GAIN*p, 1).
// Every element banks surplus input 1s in a saturating counter and pays out at most one 1 per cycle.
module stoch_fixed_gain_mult_mat #(
  parameter int unsigned COUNTER_SIZE = 8,
  parameter int unsigned GAIN         = 2,
  parameter int unsigned NUM_ROWS     = 2,
  parameter int unsigned NUM_COLS     = 2
) (
  input  logic                           CLK,
  input  logic                           nRST,
  input  logic [NUM_ROWS*NUM_COLS-1:0]   A,
  input  logic                           CLR_SAT,
  output logic [NUM_ROWS*NUM_COLS-1:0]   Y,
  output logic [NUM_ROWS*NUM_COLS-1:0]   SAT
);

  localparam int unsigned NUM_ELEM = NUM_ROWS * NUM_COLS;
  localparam int unsigned TOT_W    = COUNTER_SIZE + 1;

  localparam logic [TOT_W-1:0]        GAIN_T    = TOT_W'(GAIN);
  localparam logic [TOT_W-1:0]        SAT_LIMIT = {1'b1, {COUNTER_SIZE{1'b0}}};
  localparam logic [COUNTER_SIZE-1:0] CMAX      = '1;

  for (genvar e = 0; e < NUM_ELEM; e++) begin : g_elem
    logic [COUNTER_SIZE-1:0] cnt_q;
    logic [COUNTER_SIZE-1:0] cnt_d;
    logic [TOT_W-1:0]        total_c;
    logic                    y_d;
    logic                    sat_hit_c;
    logic                    y_q;
    logic                    sat_q;

    // One extra bit on the sum so counter + GAIN never wraps; saturation is total - 1 > CMAX.
    always_comb begin
      total_c   = {1'b0, cnt_q} + (A[e] ? GAIN_T : '0);
      sat_hit_c = (total_c > SAT_LIMIT);
      y_d       = (total_c != '0);
      cnt_d     = '0;
      if (sat_hit_c) begin
        cnt_d = CMAX;
      end else if (y_d) begin
        cnt_d = COUNTER_SIZE'(total_c - TOT_W'(1));
      end
    end

    // Saturation on the same edge outranks a clear request.
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        cnt_q <= '0;
        y_q   <= 1'b0;
        sat_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        y_q   <= y_d;
        if (sat_hit_c) begin
          sat_q <= 1'b1;
        end else if (CLR_SAT) begin
          sat_q <= 1'b0;
        end
      end
    end

    assign Y[e]   = y_q;
    assign SAT[e] = sat_q;
  end

endmodule

// File: tb/tb_stoch_fixed_gain_mult_mat.sv
// Bench for stoch_fixed_gain_mult_mat: directed tables, saturation/drain/clear sequences,
// and randomized streams against a behavioural bank-of-ones model (GAIN=2) and a passthrough (GAIN=1).
module tb_stoch_fixed_gain_mult_mat;

  localparam int unsigned CS   = 8;
  localparam int unsigned G    = 2;
  localparam int unsigned NR   = 2;
  localparam int unsigned NC   = 3;
  localparam int unsigned NE   = NR * NC;
  localparam int          CMAX = (1 << CS) - 1;

  logic          CLK;
  logic          nRST;
  logic          CLR_SAT;
  logic [NE-1:0] a2, y2, sat2;
  logic [NE-1:0] a1, y1, sat1;

  int n_checks = 0;
  int n_pass   = 0;

  stoch_fixed_gain_mult_mat #(
    .COUNTER_SIZE(CS), .GAIN(G), .NUM_ROWS(NR), .NUM_COLS(NC)
  ) u_dut (
    .CLK(CLK), .nRST(nRST), .A(a2), .CLR_SAT(CLR_SAT), .Y(y2), .SAT(sat2)
  );

  stoch_fixed_gain_mult_mat #(
    .COUNTER_SIZE(CS), .GAIN(1), .NUM_ROWS(NR), .NUM_COLS(NC)
  ) u_dut_g1 (
    .CLK(CLK), .nRST(nRST), .A(a1), .CLR_SAT(CLR_SAT), .Y(y1), .SAT(sat1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [NE-1:0] act, input logic [NE-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #7;
    nRST = 1'b1;
    #1;
  endtask

  typedef struct {
    logic a0;
    logic clr;
    logic exp_y0;
    logic exp_sat0;
  } vec_t;

  vec_t tbl[16];

  // Behavioural model state: outstanding 1s owed per element, plus sticky flags.
  int            bank[NE];
  logic [NE-1:0] m_y, m_sat;

  task automatic model_edge(input logic [NE-1:0] a, input logic clr);
    for (int e = 0; e < NE; e++) begin
      int owed;
      owed = bank[e] + (a[e] ? G : 0);
      if (owed > 0) begin
        m_y[e] = 1'b1;
        owed   = owed - 1;
      end else begin
        m_y[e] = 1'b0;
      end
      if (owed > CMAX) begin
        owed      = CMAX;
        m_sat[e]  = 1'b1;
      end else if (clr) begin
        m_sat[e]  = 1'b0;
      end
      bank[e] = owed;
    end
  endtask

  initial begin
    int ones;
    int bad;
    int thr[NE];
    logic [NE-1:0] prev_a1;
    logic [NE-1:0] ra;
    logic          rclr;

    nRST = 1'b0; CLR_SAT = 1'b0;
    a2 = '1; a1 = '1;

    // Reset held: outputs stay low despite clocks and all-ones input.
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rst_y", y2, '0);
      check("rst_sat", sat2, '0);
      check("rst_y_g1", y1, '0);
    end
    a2 = '0; a1 = '0;
    #2 nRST = 1'b1;

    // Density doubling on element 0: A=1000... -> Y=1100...
    for (int k = 0; k < 16; k++) begin
      tbl[k].a0       = (k % 4 == 0);
      tbl[k].clr      = (k == 7);
      tbl[k].exp_y0   = (k % 4 < 2);
      tbl[k].exp_sat0 = 1'b0;
    end
    for (int k = 0; k < 16; k++) begin
      a2      = {{(NE-1){1'b0}}, tbl[k].a0};
      CLR_SAT = tbl[k].clr;
      tick();
      check("dbl_y", y2, {{(NE-1){1'b0}}, tbl[k].exp_y0});
      check("dbl_sat", sat2, {{(NE-1){1'b0}}, tbl[k].exp_sat0});
    end
    a2 = '0; CLR_SAT = 1'b0;
    do_reset();

    // Saturation on element 1: constant 1s from reset.
    a2 = NE'(2);
    bad = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (y2 !== NE'(2)) bad++;
      if (k == 255) check("sat_before", sat2, '0);
      if (k == 256) check("sat_rise", sat2, NE'(2));
    end
    check_int("sat_y_all_ones", bad, 0);

    // Drain: exactly CMAX more 1s, then zeros.
    a2 = '0;
    ones = 0;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (y2[1]) ones++;
      else break;
    end
    check_int("drain_count", ones, CMAX);
    tick();
    check("drain_zero", y2, '0);
    check("sat_sticky", sat2, NE'(2));

    // Clear pulse with no saturation pending.
    CLR_SAT = 1'b1;
    tick();
    CLR_SAT = 1'b0;
    check("clr_sat", sat2, '0);

    // Re-saturate with clear held high: saturation wins.
    CLR_SAT = 1'b1;
    a2 = NE'(2);
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (k == 255) check("clrhold_before", sat2, '0);
    end
    check("clrhold_sat", sat2, NE'(2));
    check("clrhold_y", y2, NE'(2));

    // Asynchronous reset mid-cycle drops outputs before the next edge and discards the bank.
    #3 nRST = 1'b0;
    #1;
    check("async_y", y2, '0);
    check("async_sat", sat2, '0);
    a2 = '0; CLR_SAT = 1'b0;
    #2 nRST = 1'b1;
    tick();
    check("post_rst_y", y2, '0);

    // Randomized streams, distinct density per element.
    do_reset();
    for (int e = 0; e < NE; e++) bank[e] = 0;
    m_y = '0; m_sat = '0; prev_a1 = '0;
    thr = '{8, 25, 40, 50, 70, 95};
    for (int k = 0; k < 1000; k++) begin
      for (int e = 0; e < NE; e++) ra[e] = ($urandom_range(0, 99) < thr[e]);
      rclr    = ($urandom_range(0, 24) == 0);
      a2      = ra;
      a1      = NE'($urandom);
      CLR_SAT = rclr;
      tick();
      model_edge(ra, rclr);
      check("rnd_y", y2, m_y);
      check("rnd_sat", sat2, m_sat);
      check("g1_y", y1, a1);
      check("g1_sat", sat1, '0);
      prev_a1 = a1;
    end
    tick();
    check("g1_last", y1, prev_a1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stoch_fixed_gain_mult_mat.md
# stoch_fixed_gain_mult_mat

Element-wise stochastic fixed-gain multiplier for matrices: each output bitstream carries min(GAIN·p, 1), where p is the 1-density of the corresponding input bitstream. It is the inverse operation of the fixed-gain divider and restores scale after a divide stage in stochastic matrix datapaths. Inputs and outputs are row-major bit vectors, one stochastic bit per element per clock. Each element has a per-element saturating carry counter that banks excess 1s. Each element also has a sticky saturation flag for clipping detection.

## Interface
- COUNTER_SIZE, 8, width of each element's carry counter (max value CMAX = 2^COUNTER_SIZE − 1)
- GAIN, 2, integer gain; legal range 1 ≤ GAIN ≤ CMAX
- NUM_ROWS, 2, matrix rows
- NUM_COLS, 2, matrix columns
- Reset is asynchronous and active-low.
- CLK  input  1  single clock; all state updates on rising edge
- nRST  input  1  asynchronous active-low reset
- A  input  NUM_ROWS*NUM_COLS  input bitstreams; element (i,j) at bit i*NUM_COLS+j
- CLR_SAT  input  1  synchronous clear of all SAT flags
- Y  output  NUM_ROWS*NUM_COLS  registered output bitstreams, same indexing as A
- SAT  output  NUM_ROWS*NUM_COLS  sticky per-element saturation flags, same indexing

## Operation
- Elements are fully independent. Each element e has counter C[e] (COUNTER_SIZE bits, unsigned), output register Y[e], and flag SAT[e].
- Each rising edge, per element:
  - Compute total = C + (A[e] ? GAIN : 0) in COUNTER_SIZE+1 bits. This width cannot overflow.
  - If total ≥ 1: Y ← 1 and C ← min(total − 1, CMAX).
  - If total = 0: Y ← 0 and C stays 0.
- Saturation occurs when total − 1 > CMAX. In that case C ← CMAX and SAT ← 1. The excess 1s are dropped, and this is the only source of clipping error.
- SAT update priority:
  - CLR_SAT = 1 clears SAT on that edge, but a saturation on the same edge wins and SAT is 1.
  - Otherwise SAT holds.
- Long-run behaviour: the density of Y equals min(GAIN·p, 1) when no saturation occurs.
- If GAIN·p > 1, C climbs to CMAX, SAT sets, and Y stays constantly 1.
- GAIN = 1: C stays 0 and Y is A delayed by one cycle.

## Timing
- Reset (nRST low, asynchronous): C = 0, Y = 0, SAT = 0 for all elements, immediately and independent of CLK. Reset asserted mid-stream discards banked counts.
- After nRST deasserts, the first rising edge processes A normally.
- Latency is 1 cycle: an A bit sampled on edge k affects Y visible after edge k. Banked 1s emerge on subsequent cycles, at most one per cycle per element.
- Y and SAT are driven directly from flops with no combinational path from A.
- Drain time: from C = n with A held 0, Y outputs exactly n more 1s, then 0s.

## Test plan
- Reset check: hold nRST low, toggle CLK and drive A = all 1s -> Y = 0, SAT = 0 throughout. Assert nRST asynchronously mid-stream -> Y and SAT drop before the next edge.
- Density doubling (GAIN=2, COUNTER_SIZE=8): A[0] repeating 1000 -> Y[0] repeating 1100 after 1-cycle latency (density 0.5). Other elements held at 0 -> their Y stays 0.
- Saturation (GAIN=2): A[1] = 1 continuously from reset -> Y[1] = 1 every cycle; C reaches 255 after edge 255; SAT[1] rises after edge 256. Then A[1] = 0 -> exactly 255 further 1s, then Y[1] = 0.
- SAT clear priority: SAT[1] set and A[1] = 0 -> pulse CLR_SAT, SAT[1] = 0 the next cycle. Saturating again with CLR_SAT held high -> SAT[1] = 1.
- GAIN=1 passthrough: random A, 1000 cycles -> Y equals A delayed one cycle bit-exact, and SAT is never set.
- Matrix indexing (NUM_ROWS=2, NUM_COLS=3): drive a distinct pattern on each bit i*3+j -> each Y bit matches its scalar reference model, with no cross-element interaction.
